// File: rtl/trace_line_checker_if.sv
// Character stream and result bus between a trace source and trace_line_checker.
interface trace_line_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             char_valid;
  logic [7:0]       char;
  logic [15:0]      freq;
  logic [1:0]       format_type;
  logic [3:0]       error_code;
  logic [CNT_W-1:0] line_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    output char_valid, char, freq,
    input  format_type, error_code, line_count, error_count
  );

  modport slave (
    input  char_valid, char, freq,
    output format_type, error_code, line_count, error_count
  );
endinterface

// File: rtl/trace_line_checker.sv
// Streaming checker for CPU trace lines, one ASCII character per accepted cycle.
// Optional statistics counters are enabled by defining TRACE_CHECKER_STATS_EN.
module trace_line_checker #(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned GRF_MAX     = 31,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4FFF,
  parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
  parameter int unsigned CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  trace_line_checker_if.slave tl
);

  localparam int unsigned DEC_MAX    = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int unsigned MAX_DIGITS = (DEC_MAX > 8) ? DEC_MAX : 8;
  localparam int unsigned CW         = $clog2(MAX_DIGITS + 1);

  localparam logic [CW-1:0] TIME_N = CW'(TIME_DIGITS);
  localparam logic [CW-1:0] GRF_N  = CW'(GRF_DIGITS);
  localparam logic [CW-1:0] HEX_N  = CW'(8);
  localparam logic [15:0]   GRF_MAX_W = 16'(GRF_MAX);
  localparam logic [32:0]   PC_SPAN   = {1'b0, PC_HI - PC_LO};
  localparam logic [32:0]   ADDR_SPAN = {1'b0, ADDR_HI - ADDR_LO};

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  typedef enum logic [3:0] {
    IDLE, TIME, PC, SP1, GRF, ADDR, SP2, EQ, SP3, DATA, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    time_q, time_d, grf_q, grf_d;
  logic [31:0]    pc_q, pc_d, addr_q, addr_d;
  logic           is_mem_q, is_mem_d;
  logic [1:0]     ft_q, ft_d;
  logic [3:0]     ec_q, ec_d;

  logic           is_dec, is_hex;
  logic [3:0]     dig, nib;
  logic [CW-1:0]  cnt_inc;
  logic [15:0]    time_mask;
  logic [32:0]    pc_off, addr_off;
  logic           err_time, err_pc, err_addr, err_grf;

  // Character classification and line checks on the accumulated fields
  always_comb begin
    is_dec    = (tl.char >= 8'h30) && (tl.char <= 8'h39);
    is_hex    = is_dec || ((tl.char >= 8'h61) && (tl.char <= 8'h66));
    dig       = 4'(tl.char - 8'h30);
    nib       = is_dec ? dig : 4'(tl.char - 8'h57);
    cnt_inc   = cnt_q + CW'(1);
    time_mask = (tl.freq >> 1) - 16'd1;
    pc_off    = {1'b0, pc_q} - {1'b0, PC_LO};
    addr_off  = {1'b0, addr_q} - {1'b0, ADDR_LO};
    err_time  = (time_q & time_mask) != 16'd0;
    err_pc    = (pc_off > PC_SPAN) || (pc_q[1:0] != 2'b00);
    err_addr  = is_mem_q && ((addr_off > ADDR_SPAN) || (addr_q[1:0] != 2'b00));
    err_grf   = !is_mem_q && (grf_q > GRF_MAX_W);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    time_d   = time_q;
    grf_d    = grf_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    is_mem_d = is_mem_q;
    ft_d     = ft_q;
    ec_d     = ec_q;
    if (tl.char_valid) begin
      // Any accepted character drops the previous result; illegal input falls to IDLE
      state_d = IDLE;
      ft_d    = 2'b00;
      ec_d    = 4'b0000;
      if (tl.char == CH_CARET) begin
        state_d  = TIME;
        cnt_d    = '0;
        time_d   = '0;
        grf_d    = '0;
        pc_d     = '0;
        addr_d   = '0;
        is_mem_d = 1'b0;
      end else begin
        case (state_q)
          TIME: begin
            if (is_dec && (cnt_q < TIME_N)) begin
              state_d = TIME;
              time_d  = time_q * 16'd10 + {12'd0, dig};
              cnt_d   = cnt_inc;
            end else if ((tl.char == CH_AT) && (cnt_q != '0)) begin
              state_d = PC;
              cnt_d   = '0;
            end
          end
          PC: begin
            if (is_hex && (cnt_q < HEX_N)) begin
              state_d = PC;
              pc_d    = {pc_q[27:0], nib};
              cnt_d   = cnt_inc;
            end else if ((tl.char == CH_COLON) && (cnt_q == HEX_N)) begin
              state_d = SP1;
              cnt_d   = '0;
            end
          end
          SP1: begin
            if (tl.char == CH_SPACE) begin
              state_d = SP1;
            end else if (tl.char == CH_DOLLAR) begin
              state_d  = GRF;
              is_mem_d = 1'b0;
            end else if (tl.char == CH_STAR) begin
              state_d  = ADDR;
              is_mem_d = 1'b1;
            end
          end
          GRF: begin
            if (is_dec && (cnt_q < GRF_N)) begin
              state_d = GRF;
              grf_d   = grf_q * 16'd10 + {12'd0, dig};
              cnt_d   = cnt_inc;
            end else if ((cnt_q != '0) && (tl.char == CH_SPACE)) begin
              state_d = SP2;
            end else if ((cnt_q != '0) && (tl.char == CH_LT)) begin
              state_d = EQ;
            end
          end
          ADDR: begin
            if (is_hex && (cnt_q < HEX_N)) begin
              state_d = ADDR;
              addr_d  = {addr_q[27:0], nib};
              cnt_d   = cnt_inc;
            end else if ((cnt_q == HEX_N) && (tl.char == CH_SPACE)) begin
              state_d = SP2;
            end else if ((cnt_q == HEX_N) && (tl.char == CH_LT)) begin
              state_d = EQ;
            end
          end
          SP2: begin
            if (tl.char == CH_SPACE)   state_d = SP2;
            else if (tl.char == CH_LT) state_d = EQ;
          end
          EQ: begin
            if (tl.char == CH_EQ) state_d = SP3;
          end
          SP3: begin
            if (tl.char == CH_SPACE) begin
              state_d = SP3;
            end else if (is_hex) begin
              state_d = DATA;
              cnt_d   = CW'(1);
            end
          end
          DATA: begin
            if (is_hex && (cnt_q < HEX_N)) begin
              state_d = DATA;
              cnt_d   = cnt_inc;
            end else if ((tl.char == CH_HASH) && (cnt_q == HEX_N)) begin
              state_d = DONE;
              ft_d    = is_mem_q ? 2'b10 : 2'b01;
              ec_d    = {err_grf, err_addr, err_pc, err_time};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      time_q   <= '0;
      grf_q    <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      is_mem_q <= 1'b0;
      ft_q     <= '0;
      ec_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      grf_q    <= grf_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      is_mem_q <= is_mem_d;
      ft_q     <= ft_d;
      ec_q     <= ec_d;
    end
  end

  assign tl.format_type = ft_q;
  assign tl.error_code  = ec_q;

`ifdef TRACE_CHECKER_STATS_EN
  logic             done_entry;
  logic [CNT_W-1:0] line_cnt_q, err_cnt_q;

  assign done_entry = tl.char_valid && (state_d == DONE);

  // Saturating line and error statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt_q <= CNT_W'(0);
      err_cnt_q  <= CNT_W'(0);
    end else if (done_entry) begin
      if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + CNT_W'(1);
      if ((ec_d != 4'b0000) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign tl.line_count  = line_cnt_q;
  assign tl.error_count = err_cnt_q;
`else
  assign tl.line_count  = CNT_W'(0);
  assign tl.error_count = CNT_W'(0);
`endif

endmodule
